// File: rtl/movavg_stream.sv
// Moving sum / average over the last DEPTH accepted samples.
// Circular buffer plus running accumulator; registered output, latency 1.
module movavg_stream #(
    parameter int WL    = 64,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            mode,
    input  logic                            in_valid,
    input  logic [WL-1:0]                   din,
    output logic                            out_valid,
    output logic [WL+$clog2(DEPTH)-1:0]     dout,
    output logic                            full
);

    localparam int LOG2D = $clog2(DEPTH);
    localparam int OW    = WL + LOG2D;
    localparam int CW    = LOG2D + 1;

    logic [WL-1:0]    smp_q [DEPTH];
    logic [OW-1:0]    acc_q, acc_d;
    logic [LOG2D-1:0] wptr_q, wptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [OW-1:0]    dout_q, dout_d;
    logic             ov_q, ov_d;
    logic             flush;
    logic             acc_en;
    logic [OW-1:0]    new_sum;

    assign flush  = reset | clear;
    assign acc_en = in_valid & ~flush;

    // Subtract is exact: acc_q always equals the sum of the buffer entries.
    assign new_sum = acc_q + OW'(din) - OW'(smp_q[wptr_q]);

    always_comb begin
        acc_d  = acc_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        dout_d = dout_q;
        ov_d   = 1'b0;
        if (acc_en) begin
            acc_d  = new_sum;
            wptr_d = wptr_q + LOG2D'(1);
            ov_d   = 1'b1;
            dout_d = mode ? (new_sum >> LOG2D) : new_sum;
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cnt_q >= CW'(DEPTH - 1)) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                smp_q[i] <= '0;
            end
        end else if (acc_en) begin
            smp_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            acc_q  <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            dout_q <= '0;
            ov_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            dout_q <= dout_d;
            ov_q   <= ov_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = ov_q;
    assign full      = full_q;

endmodule
